// File: rtl/pipelined_addsub.sv
// pipelined_addsub: parametrised integer adder/subtractor split into
// CHUNK-bit slices, one slice per pipeline stage, with a valid/ready
// handshake and ALU flags on the registered result.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The producer holds in_valid/a/b/op/cin until in_ready; the block holds
// out_valid and s/flags until out_ready. The whole pipe advances together
// when the output register is empty or being drained, so
// in_ready = !out_valid || out_ready and there is no combinational path
// from in_valid to in_ready.

module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NSTAGES = WIDTH / CHUNK;
  localparam int NGROUPS = CHUNK / 4;

  // Slices are built from 4-bit lookahead groups and the stage count must
  // be whole; anything else is a configuration mistake.
  if (!(CHUNK == 4 || CHUNK == 16 || CHUNK == 32) ||
      (WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_param
    $error("pipelined_addsub: unsupported WIDTH/CHUNK combination");
  end

  // One CHUNK-bit slice add: bit generate/propagate, 4-bit group
  // generate/propagate, lookahead across groups, then lookahead inside
  // each group. Returns {carry_out, sum}.
  function automatic logic [CHUNK:0] cla_add(input logic [CHUNK-1:0] x,
                                             input logic [CHUNK-1:0] y,
                                             input logic             ci);
    logic [CHUNK-1:0]   g;
    logic [CHUNK-1:0]   p;
    logic [CHUNK-1:0]   c;
    logic [NGROUPS-1:0] gg;
    logic [NGROUPS-1:0] pg;
    logic [NGROUPS:0]   cg;
    logic               term;
    g = x & y;
    p = x ^ y;
    for (int j = 0; j < NGROUPS; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      pg[j] = &p[4*j +: 4];
    end
    // Group carries in flattened sum-of-products form: each group carry-in
    // depends only on ci and the group g/p terms, not on earlier carries.
    cg    = '0;
    cg[0] = ci;
    for (int j = 0; j < NGROUPS; j++) begin
      term = ci;
      for (int m = 0; m <= j; m++) term = term & pg[m];
      cg[j+1] = term;
      for (int i = 0; i <= j; i++) begin
        term = gg[i];
        for (int m = i + 1; m <= j; m++) term = term & pg[m];
        cg[j+1] = cg[j+1] | term;
      end
    end
    c = '0;
    for (int j = 0; j < NGROUPS; j++) begin
      c[4*j]   = cg[j];
      c[4*j+1] = g[4*j] | (p[4*j] & cg[j]);
      c[4*j+2] = g[4*j+1]
               | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & cg[j]);
      c[4*j+3] = g[4*j+2]
               | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & cg[j]);
    end
    return {cg[NGROUPS], p ^ c};
  endfunction

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Pre-decode: subtraction is a + ~b + 1; ADC/SBC take the carry from cin.
  assign b_eff = op[0] ? ~b : b;
  assign c0    = op[1] ? cin : op[0];

  // Stage k works on slice k. acc carries the finished sum slices below k
  // and the untouched slices of a from k upward, so one word travels down
  // the pipe. bh keeps only the b_eff slices not yet consumed.
  for (genvar k = 0; k < NSTAGES; k++) begin : stg
    logic                   v_i;
    logic                   c_i;
    logic [WIDTH-1:0]       acc_i;
    logic [WIDTH-1:k*CHUNK] bh_i;
    logic [CHUNK:0]         add_r;
    logic [WIDTH-1:0]       acc_o;
    logic                   c_o;

    if (k == 0) begin : g_in
      assign v_i   = in_valid;
      assign c_i   = c0;
      assign acc_i = a;
      assign bh_i  = b_eff;
    end else begin : g_reg
      // Skew register between stage k-1 and stage k; holds while stalled.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_i   <= 1'b0;
          c_i   <= 1'b0;
          acc_i <= '0;
          bh_i  <= '0;
        end else if (advance) begin
          v_i   <= stg[k-1].v_i;
          c_i   <= stg[k-1].c_o;
          acc_i <= stg[k-1].acc_o;
          bh_i  <= stg[k-1].bh_i[WIDTH-1:k*CHUNK];
        end
      end
    end

    assign add_r = cla_add(acc_i[k*CHUNK +: CHUNK], bh_i[k*CHUNK +: CHUNK], c_i);
    assign c_o   = add_r[CHUNK];

    // Replace slice k of the travelling word with its sum.
    always_comb begin
      acc_o                    = acc_i;
      acc_o[k*CHUNK +: CHUNK]  = add_r[CHUNK-1:0];
    end
  end

  // The last stage still sees a and b_eff MSBs on its inputs, which is
  // what the signed-overflow rule needs.
  logic [WIDTH-1:0] fin_sum;
  logic             fin_c;
  logic             fin_ovf;

  assign fin_sum = stg[NSTAGES-1].acc_o;
  assign fin_c   = stg[NSTAGES-1].c_o;
  assign fin_ovf = (stg[NSTAGES-1].acc_i[WIDTH-1] == stg[NSTAGES-1].bh_i[WIDTH-1]) &&
                   (fin_sum[WIDTH-1] != stg[NSTAGES-1].acc_i[WIDTH-1]);

  // Output register: result and flags load together, only for a real
  // operation, so the last result stays put across bubbles and stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else if (advance) begin
      out_valid <= stg[NSTAGES-1].v_i;
      if (stg[NSTAGES-1].v_i) begin
        s    <= fin_sum;
        cout <= fin_c;
        ovf  <= fin_ovf;
        zero <= (fin_sum == '0);
        neg  <= fin_sum[WIDTH-1];
      end
    end
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined integer adder/subtractor; successor to the fixed-width combinational CLA adders.
- Operand width is split into CHUNK-bit slices. Each pipeline stage adds one slice with a combinational CLA and registers the carry into the next stage.
- Full throughput of one operation per cycle, with valid/ready handshake and ALU flags.
- Sits between the operand-select logic and result writeback of the CPU32 execute path.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of CHUNK, WIDTH >= CHUNK.
- CHUNK, 16, bits added per pipeline stage; must be 4, 16 or 32. NSTAGES = WIDTH/CHUNK.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block accepts when in_valid & in_ready.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  00 ADD a+b; 01 SUB a+~b+1; 10 ADC a+b+cin; 11 SBC a+~b+cin.
- cin  in  1  carry-in, used by ADC/SBC only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- s  out  WIDTH  result (mod 2^WIDTH).
- cout  out  1  carry out of MSB. For SUB/SBC, 1 = no borrow.
- ovf  out  1  signed overflow: (a_eff[MSB]==b_eff[MSB]) && s[MSB]!=a_eff[MSB], where b_eff is the possibly inverted b.
- zero  out  1  s == 0.
- neg  out  1  s[WIDTH-1].

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All stage valid bits clear; out_valid=0.
  - s, cout, ovf, zero, neg = 0.
  - in_ready = 1 in the cycle after reset.
  - Reset mid-operation discards all in-flight operations; no partial result is ever presented.
- Pre-decode (combinational at input):
  - b_eff = op[0] ? ~b : b.
  - c0 = op[1] ? cin : op[0].
- Stages:
  - Stage k (0..NSTAGES-1) adds slice k of a and b_eff with the carry registered by stage k-1 (c0 for stage 0).
  - Each slice uses a 4-bit-group CLA: generate/propagate per bit, group pg/gg, carry lookahead within the slice.
  - Unused upper slices and already-computed lower sum slices travel through skew registers alongside the carry.
- Pipeline output register:
  - Stage NSTAGES-1 output lands in the output register, so latency = NSTAGES cycles from accept to out_valid with no stall (2 for defaults; 1 when CHUNK=WIDTH).
  - Flags are computed from the final slice and the complete s, and registered together with s.
- Stall:
  - advance = !out_valid | out_ready; in_ready = advance.
  - When advance=0, every stage register, including its valid bit, holds.
  - When advance=1, all stages shift by one; bubbles (valid=0) propagate as bubbles.
- Handshake rules:
  - Outputs s/flags are stable while out_valid=1 and out_ready=0.
  - Results emerge in acceptance order with none dropped or duplicated.
  - Simultaneous accept and output consume in the same cycle sustains 1 op/cycle.
- Inputs a, b, op and cin are sampled only on accept. in_valid=0 with in_ready=1 inserts a bubble.
- cin is ignored for ADD/SUB.

Test Plan:
- ADD 0xFFFF_FFFF + 0x0000_0001 -> after 2 cycles: s=0x0000_0000, cout=1, zero=1, ovf=0, neg=0.
- ADD 0x0000_FFFF + 1, then ADD 0x7FFF_FFFF + 1 back-to-back:
  - first result s=0x0001_0000, ovf=0 (carry crosses the slice boundary);
  - next cycle s=0x8000_0000, ovf=1, neg=1.
- SUB 5 - 7 -> s=0xFFFF_FFFE, cout=0, neg=1, ovf=0. SUB 7 - 5 -> s=2, cout=1.
- ADC 1+1 with cin=1 -> s=3. SBC 0x10 - 0x01 with cin=0 -> s=0x0E, cout=1.
- Backpressure: issue 4 back-to-back ops; hold out_ready=0 for 3 cycles after the first out_valid.
  - in_ready drops, s stays constant during the hold.
  - All 4 results arrive in order, none lost.
  - 1 op/cycle resumes when out_ready=1.
- Reset mid-flight: assert rst for 1 cycle with 2 ops in the pipeline -> out_valid=0 from the next cycle, no stale result appears, in_ready=1.
- Repeat random ADD/SUB/ADC/SBC against a reference model for WIDTH=64/CHUNK=16 (latency 4) and WIDTH=32/CHUNK=32 (latency 1).
